serializer: RTL

//  Parallel-to-serial stage directly upstream of the deserializer.

---
 rtl/serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/serializer.sv
// Parallel-to-serial stage: shifts a variable-length word out MSB-first, one bit per clock.
// A one-word holding register keeps consecutive words back-to-back with no idle cycle.
module serializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = $clog2(DATA_W),
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [MOD_W:0] LEN_FULL = (MOD_W + 1)'(DATA_W);
  localparam logic [MOD_W:0] LEN_MIN  = (MOD_W + 1)'(MIN_LEN);

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [MOD_W:0]    r_cnt;
  logic [DATA_W-1:0] r_hold_data;
  logic [MOD_W:0]    r_hold_len;
  logic              r_hold_full;

  logic [0:0]        w_state_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [MOD_W:0]    w_cnt_nxt;
  logic [DATA_W-1:0] w_hold_data_nxt;
  logic [MOD_W:0]    w_hold_len_nxt;
  logic              w_hold_full_nxt;

  logic [MOD_W:0]    w_len;
  logic              w_accept;
  logic              w_last;

  // A length field of zero encodes a full-width word.
  assign w_len    = (data_mod_i == '0) ? LEN_FULL : {1'b0, data_mod_i};
  assign w_accept = data_val_i & ~r_hold_full & (w_len >= LEN_MIN);
  assign w_last   = (r_cnt == (MOD_W + 1)'(1));

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_hold_data_nxt = r_hold_data;
    w_hold_len_nxt  = r_hold_len;
    w_hold_full_nxt = r_hold_full;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = data_i;
          w_cnt_nxt   = w_len;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          // Held word takes priority; busy_o blocks new input while it is full.
          if (r_hold_full) begin
            w_shift_nxt     = r_hold_data;
            w_cnt_nxt       = r_hold_len;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = data_i;
            w_cnt_nxt   = w_len;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - 1'b1;
          if (w_accept) begin
            w_hold_data_nxt = data_i;
            w_hold_len_nxt  = w_len;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold_data <= '0;
      r_hold_len  <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_len  <= w_hold_len_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  assign ser_data_val_o = (r_state == ST_SHIFT);
  assign ser_data_o     = ser_data_val_o & r_shift[DATA_W-1];
  assign busy_o         = r_hold_full;

endmodule
